program_loader: RTL

Write-side counterpart of the CPU's immediate-field decoding. Accepts instruction-build requests: a format select, a base opcode word and an 8-bit immediate value.
- Range-checks the immediate and inserts it into the format's immediate field.
- Writes the packed 8-bit instruction word into the instruction memory write port at an auto-incrementing address.
- Sits between the host/test loader and instruction memory; used to fill program memory before the CPU is released.

---
 rtl/program_loader_pkg.sv | 19 +
 rtl/program_loader_imm_field_inserter.sv | 37 +++
 rtl/program_loader.sv | 112 +++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: instruction formats, FSM states
// and the instruction word width.
package program_loader_pkg;

    localparam int WORD_W = 8;

    localparam logic [1:0] FMT_IMM3  = 2'b00;
    localparam logic [1:0] FMT_IMM4  = 2'b01;
    localparam logic [1:0] FMT_IMM5S = 2'b10;
    localparam logic [1:0] FMT_NONE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/program_loader_imm_field_inserter.sv
// Combinational packer: drops an immediate into the field of the selected
// instruction format and reports whether the value fits that field.
module imm_field_inserter
    import program_loader_pkg::*;
(
    input  logic [1:0]        i_fmt,
    input  logic [WORD_W-1:0] i_base,
    input  logic [WORD_W-1:0] i_imm,
    output logic [WORD_W-1:0] o_word,
    output logic              o_in_range
);

    always_comb begin
        o_word     = i_base;
        o_in_range = 1'b1;
        case (i_fmt)
            FMT_IMM3: begin
                o_word     = {i_base[7:5], i_imm[2:0], i_base[1:0]};
                o_in_range = (i_imm[7:3] == 5'd0);
            end
            FMT_IMM4: begin
                o_word     = {i_base[7:4], i_imm[3:0]};
                o_in_range = (i_imm[7:4] == 4'd0);
            end
            FMT_IMM5S: begin
                o_word     = {i_base[7:5], i_imm[4:0]};
                // Signed 5-bit field: upper bits must be copies of the sign bit.
                o_in_range = (i_imm[7:4] == {4{i_imm[4]}});
            end
            default: begin
                o_word     = i_base;
                o_in_range = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/program_loader.sv
// Builds instruction words from host requests and writes them to instruction
// memory at an auto-incrementing address, one word every two cycles.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [WORD_W-1:0] in_base,
    input  logic [WORD_W-1:0] in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              range_err,
    output logic [ADDR_W-1:0] err_addr,
    output state_t            dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_word;
    logic              r_last;
    logic              r_in_range;
    logic              r_full;
    logic              r_range_err;
    logic [ADDR_W-1:0] r_err_addr;

    logic [WORD_W-1:0] w_word;
    logic              w_in_range;

    imm_field_inserter u_inserter (
        .i_fmt      (in_fmt),
        .i_base     (in_base),
        .i_imm      (in_imm),
        .o_word     (w_word),
        .o_in_range (w_in_range)
    );

    // Handshake: a request transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready never depends on in_valid, and start
    // withdraws both in_ready and mem_we so an aborted cycle stores/writes nothing.
    assign in_ready  = (r_state == LOAD)  && !start;
    assign mem_we    = (r_state == WRITE) && !start;
    assign busy      = (r_state == LOAD) || (r_state == WRITE);
    assign done      = (r_state == DONE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_word;
    assign full      = r_full;
    assign range_err = r_range_err;
    assign err_addr  = r_err_addr;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_word      <= '0;
            r_last      <= 1'b0;
            r_in_range  <= 1'b1;
            r_full      <= 1'b0;
            r_range_err <= 1'b0;
            r_err_addr  <= '0;
        end else if (start) begin
            r_state     <= LOAD;
            r_addr      <= '0;
            r_full      <= 1'b0;
            r_range_err <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        r_word     <= w_word;
                        r_last     <= in_last;
                        r_in_range <= w_in_range;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (!r_in_range) begin
                        r_range_err <= 1'b1;
                        if (!r_range_err) r_err_addr <= r_addr;
                    end
                    // The counter never wraps: the top address always ends the load.
                    if (r_addr == LAST_ADDR) begin
                        r_full  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_last) begin
                        r_state <= DONE;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= LOAD;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

endmodule
